// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: state encodings and default timing constants shared by the count sequencer.
package count_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam int DEF_TICK_DIV  = 1_000_000;
    localparam int DEF_DB_CYCLES = 100_000;

endpackage

// File: rtl/count_sequencer_tick_prescaler.sv
// tick_prescaler: counts 0..DIV-1 while enabled and pulses tick on the terminal count.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = enable && cnt == W'(DIV - 1);

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: run/step/halt control for the display counter with a prescaled tick.
// Optional step debounce is enabled by defining COUNT_SEQ_DEBOUNCE_EN.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             ADC_CLK_10,
    input  logic             rst,
    input  logic             run,
    input  logic             dir,
    input  logic             wrap_mode,
    input  logic             step_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_dir,
    output logic             cnt_clr,
    output logic [1:0]       state,
    output logic             done,
    output logic             heartbeat
);

    state_t st;
    logic   step_s1, step_s2, step_lvl, step_prev, step_pulse;
    logic   tick, at_term;

    assign state      = st;
    assign step_pulse = step_prev & ~step_lvl;
    assign at_term    = dir ? (cnt_val == '0) : (cnt_val == '1);

    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            step_s1   <= 1'b1;
            step_s2   <= 1'b1;
            step_prev <= 1'b1;
        end else begin
            step_s1   <= step_n;
            step_s2   <= step_s1;
            step_prev <= step_lvl;
        end
    end

`ifdef COUNT_SEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;
    logic            db_level;

    // a new level must persist DB_CYCLES consecutive cycles before it is accepted
    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b1;
        end else if (step_s2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_cnt   <= '0;
            db_level <= step_s2;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign step_lvl = db_level;
`else
    assign step_lvl = step_s2;
`endif

    // held clear outside RUN so every entry into RUN starts a full tick period
    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .clk(ADC_CLK_10),
        .rst(rst),
        .clear(st != ST_RUN),
        .enable(st == ST_RUN),
        .tick(tick)
    );

    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            st        <= ST_IDLE;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
            cnt_dir   <= 1'b0;
            done      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            cnt_dir <= dir;
            case (st)
                ST_IDLE: begin
                    cnt_clr <= clr;
                    if (run) begin
                        st <= ST_RUN;
                    end else if (step_pulse) begin
                        st        <= ST_STEP;
                        cnt_en    <= 1'b1;
                        heartbeat <= ~heartbeat;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        st <= ST_IDLE;
                    end else if (tick && !wrap_mode && at_term) begin
                        st   <= ST_HALT;
                        done <= 1'b1;
                    end else if (tick) begin
                        cnt_en    <= 1'b1;
                        heartbeat <= ~heartbeat;
                    end
                end
                ST_STEP: st <= ST_IDLE;
                ST_HALT: begin
                    cnt_clr <= clr;
                    if (!run) begin
                        st   <= ST_IDLE;
                        done <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: randomized self-checking bench with a counter datapath model and tick-schedule reference.
module tb_count_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1, run = 1'b0, dir = 1'b0, wrap_mode = 1'b0, step_n = 1'b1, clr = 1'b0;
    logic [7:0] cnt_val = 8'd0;
    logic       cnt_en, cnt_dir, cnt_clr, done, heartbeat;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    bit hb_exp = 1'b0;

    count_sequencer #(
        .CNT_W(8),
        .TICK_DIV(TD),
        .DB_CYCLES(3)
    ) dut (
        .ADC_CLK_10(clk),
        .rst(rst),
        .run(run),
        .dir(dir),
        .wrap_mode(wrap_mode),
        .step_n(step_n),
        .clr(clr),
        .cnt_val(cnt_val),
        .cnt_en(cnt_en),
        .cnt_dir(cnt_dir),
        .cnt_clr(cnt_clr),
        .state(state),
        .done(done),
        .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    // one clock; the 8-bit counter datapath reacts to the strobes present at the edge
    task automatic cyc();
        logic en_q, clr_q, dir_q;
        en_q  = cnt_en;
        clr_q = cnt_clr;
        dir_q = cnt_dir;
        @(posedge clk);
        #1;
        if (clr_q)
            cnt_val = 8'd0;
        else if (en_q)
            cnt_val = dir_q ? cnt_val - 8'd1 : cnt_val + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; clr = 1'b0; step_n = 1'b1; wrap_mode = 1'b0; dir = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        hb_exp = 1'b0;
    endtask

    // reference: tick every TD edges after run rises, first on edge TD+1; halt instead at terminal
    task automatic run_phase(input int ncyc, input bit d, input bit w, input bit clr_noise, input bit flip_dir);
        bit halted, is_tick, exp_en;
        halted = 1'b0;
        dir = d; wrap_mode = w; run = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            is_tick = !halted && n > 1 && (n - 1) % TD == 0;
            exp_en  = is_tick && !(!wrap_mode && (dir ? cnt_val == 8'h00 : cnt_val == 8'hFF));
            if (is_tick && !exp_en) halted = 1'b1;
            clr = clr_noise && n > 1 && $urandom_range(0, 3) == 0;
            cyc();
            if (exp_en) hb_exp = ~hb_exp;
            checks++;
            if (cnt_en !== exp_en) begin
                errors++; $display("FAIL run_cnt_en n=%0d: got %b want %b", n, cnt_en, exp_en);
            end
            checks++;
            if (state !== (halted ? 2'b11 : 2'b01) || done !== halted) begin
                errors++; $display("FAIL run_state n=%0d: got state=%b done=%b want halted=%b", n, state, done, halted);
            end
            checks++;
            if (heartbeat !== hb_exp) begin
                errors++; $display("FAIL run_heartbeat n=%0d: got %b want %b", n, heartbeat, hb_exp);
            end
            checks++;
            if (cnt_clr !== 1'b0 || cnt_dir !== dir) begin
                errors++; $display("FAIL run_clr_dir n=%0d: got clr=%b dir=%b want clr=0 dir=%b", n, cnt_clr, cnt_dir, dir);
            end
            if (flip_dir && $urandom_range(0, 5) == 0) dir = ~dir;
        end
        clr = 1'b0;
    endtask

    task automatic stop_run();
        run = 1'b0;
        cyc();
        checks++;
        if (state !== 2'b00 || done !== 1'b0 || cnt_en !== 1'b0) begin
            errors++; $display("FAIL stop_run: got state=%b done=%b en=%b want 00/0/0", state, done, cnt_en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; dir = 1'b1; step_n = 1'b0; clr = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({state, cnt_en, cnt_clr, cnt_dir, done, heartbeat} !== 7'd0) begin
            errors++; $display("FAIL reset_state: got %b want 0000000", {state, cnt_en, cnt_clr, cnt_dir, done, heartbeat});
        end
        rst = 1'b0; run = 1'b0; dir = 1'b0; step_n = 1'b1; clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if ({state, cnt_en, cnt_clr, done, heartbeat} !== 6'd0) begin
                errors++; $display("FAIL idle_quiet cycle %0d: got %b want 000000", i, {state, cnt_en, cnt_clr, done, heartbeat});
            end
        end
    endtask

    task automatic test_run_wrap();
        do_reset();
        cnt_val = 8'hFB;
        run_phase(41, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (cnt_val !== 8'h04) begin
            errors++; $display("FAIL wrap_through_ff: counter got %h want 04", cnt_val);
        end
        stop_run();
        cnt_val = 8'($urandom);
        run_phase(33, 1'($urandom), 1'b1, 1'b1, 1'b1);
        stop_run();
    endtask

    task automatic test_halt_up();
        do_reset();
        cnt_val = 8'hFD;
        run_phase(20, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'b11 || cnt_val !== 8'hFF) begin
            errors++; $display("FAIL halt_up: got state=%b cnt=%h want 11/ff", state, cnt_val);
        end
        stop_run();
    endtask

    task automatic test_halt_down();
        do_reset();
        cnt_val = 8'($urandom_range(1, 3));
        run_phase(20, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_n = (i >= 5);
            cyc();
            checks++;
            if (cnt_en !== 1'b0 || state !== 2'b11 || done !== 1'b1) begin
                errors++; $display("FAIL halt_step_ignored i=%0d: got en=%b state=%b done=%b want 0/11/1", i, cnt_en, state, done);
            end
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (cnt_clr !== 1'b1) begin
            errors++; $display("FAIL halt_clr: got %b want 1", cnt_clr);
        end
        cyc();
        checks++;
        if (cnt_clr !== 1'b0 || cnt_val !== 8'h00) begin
            errors++; $display("FAIL halt_clr_once: got clr=%b cnt=%h want 0/00", cnt_clr, cnt_val);
        end
        stop_run();
    endtask

    task automatic test_step();
        int presses, lo, hi, ens, steps, bad;
        do_reset();
        presses = 3 + $urandom_range(0, 3);
        for (int p = 0; p < presses; p++) begin
            lo = $urandom_range(2, 10);
            hi = $urandom_range(3, 8);
            dir = 1'($urandom);
            ens = 0; steps = 0; bad = 0;
            for (int i = 0; i < lo + hi; i++) begin
                step_n = (i >= lo);
                cyc();
                ens += int'(cnt_en);
                steps += int'(state == 2'b10);
                if (cnt_en !== (state == 2'b10) || state[0] !== 1'b0) bad++;
            end
            hb_exp = ~hb_exp;
            checks++;
            if (ens != 1 || steps != 1 || bad != 0) begin
                errors++; $display("FAIL step_once press %0d: got en=%0d step_cycles=%0d bad=%0d want 1/1/0", p, ens, steps, bad);
            end
            checks++;
            if (heartbeat !== hb_exp) begin
                errors++; $display("FAIL step_heartbeat press %0d: got %b want %b", p, heartbeat, hb_exp);
            end
        end
    endtask

    task automatic test_priority_and_clr();
        do_reset();
        step_n = 1'b0;
        cyc();
        cyc();
        run_phase(9, 1'b0, 1'b1, 1'b0, 1'b0);
        stop_run();
        step_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (cnt_en !== 1'b0 || state !== 2'b00) begin
                errors++; $display("FAIL step_discarded i=%0d: got en=%b state=%b want 0/00", i, cnt_en, state);
            end
        end
        cnt_val = 8'h5A;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (cnt_clr !== 1'b1 || state !== 2'b00) begin
            errors++; $display("FAIL idle_clr: got clr=%b state=%b want 1/00", cnt_clr, state);
        end
        cyc();
        checks++;
        if (cnt_clr !== 1'b0 || cnt_val !== 8'h00) begin
            errors++; $display("FAIL idle_clr_once: got clr=%b cnt=%h want 0/00", cnt_clr, cnt_val);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cnt_val = 8'($urandom);
        run_phase(7, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        hb_exp = 1'b0;
        checks++;
        if ({state, cnt_en, cnt_clr, done, heartbeat} !== 6'd0) begin
            errors++; $display("FAIL reset_mid: got %b want 000000", {state, cnt_en, cnt_clr, done, heartbeat});
        end
        rst = 1'b0;
        run_phase(10, 1'b0, 1'b1, 1'b0, 1'b0);
        stop_run();
    endtask

    initial begin
        test_reset();
        test_run_wrap();
        test_halt_up();
        test_halt_down();
        test_step();
        test_priority_and_clr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
